// File: rtl/pm_loader.sv
// Program-memory loader: takes a length/data/checksum byte frame, packs the bytes
// MSB-first into 32-bit words and writes them to consecutive program memory addresses.
module pm_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        pm_we,
  output logic [15:0] pm_addr,
  output logic [31:0] pm_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int            TW          = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_reg;
  logic [15:0]   base_reg;
  logic [15:0]   len_reg;
  logic [15:0]   count_reg;
  logic [7:0]    sum_reg;
  logic [1:0]    idx_reg;
  logic [23:0]   word_reg;
  logic [TW-1:0] tmo_reg;

  logic          accept;
  logic [TW-1:0] tmo_next;
  logic          tmo_hit;
  logic [15:0]   count_next;

  assign rx_ready = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                    (state_reg == S_DATA)   || (state_reg == S_CSUM);
  assign accept     = rx_valid && rx_ready;
  assign tmo_next   = tmo_reg + 1'b1;
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_next == TIMEOUT_LIM);
  assign count_next = count_reg + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      base_reg  <= '0;
      len_reg   <= '0;
      count_reg <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      word_reg  <= '0;
      tmo_reg   <= '0;
      pm_we     <= 1'b0;
      pm_addr   <= '0;
      pm_wdata  <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      pm_we <= 1'b0;

      // Inter-byte watchdog; an expiry abandons any partly assembled word.
      if (accept) begin
        tmo_reg <= '0;
      end else if (rx_ready) begin
        if (tmo_hit) begin
          state_reg <= S_ERR;
          error     <= 1'b1;
        end else begin
          tmo_reg <= tmo_next;
        end
      end

      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg <= S_LEN_HI;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
            base_reg  <= base_addr;
            count_reg <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            tmo_reg   <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_reg[15:8] <= rx_data;
            state_reg     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_reg[7:0] <= rx_data;
            state_reg    <= ({len_reg[15:8], rx_data} != 16'd0) ? S_DATA : S_CSUM;
          end
        end
        S_DATA: begin
          if (accept) begin
            word_reg <= {word_reg[15:0], rx_data};
            sum_reg  <= sum_reg + rx_data;
            idx_reg  <= idx_reg + 2'd1;
            if (idx_reg == 2'd3) begin
              state_reg <= S_WRITE;
              pm_we     <= 1'b1;
              pm_addr   <= base_reg + count_reg;
              pm_wdata  <= {word_reg, rx_data};
            end
          end
        end
        S_WRITE: begin
          count_reg <= count_next;
          idx_reg   <= '0;
          state_reg <= (count_next == len_reg) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          if (accept) begin
            if (rx_data == sum_reg) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state_reg <= S_ERR;
              error     <= 1'b1;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_loader.sv
// Randomised and directed frames for pm_loader, checked against a frame-level model
// that derives expected writes and final status straight from the byte stream.
module tb_pm_loader;
  localparam int TMO = 16;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        pm_we;
  logic [15:0] pm_addr;
  logic [31:0] pm_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int total = 0;
  int bad   = 0;

  logic [15:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  pm_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Record every write; the loader must never offer rx_ready while writing.
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      wr_addr_q.push_back(pm_addr);
      wr_data_q.push_back(pm_wdata);
      check_val("ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the start edge.
  task automatic do_start(input logic [15:0] base);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 16'($urandom);
  endtask

  // mode 0: valid every cycle, 1: valid every other cycle, 2: random valid.
  task automatic send_bytes(input bq_t bytes, input int mode, output int edges);
    int i;
    int cyc;
    i = 0;
    cyc = 0;
    edges = 0;
    while (i < bytes.size() && cyc < 2000) begin
      rx_data  = bytes[i];
      rx_valid = (mode == 0) || (mode == 1 && (cyc % 2) == 0) ||
                 (mode == 2 && ($urandom % 3) != 0);
      @(negedge clk);
      if (rx_valid && rx_ready) i++;
      @(posedge clk); #1;
      edges++;
      cyc++;
    end
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (i < bytes.size()) check_val("send_stalled", i, bytes.size());
  endtask

  task automatic run_frame(input logic [15:0] base, input bq_t fr, input int mode);
    int          n;
    int          edges;
    logic [7:0]  s;
    logic [7:0]  csum;
    logic [31:0] words[$];
    bit          ok;
    n = {fr[0], fr[1]};
    s = 8'd0;
    words.delete();
    for (int k = 0; k < n; k++) begin
      words.push_back({fr[2+4*k], fr[3+4*k], fr[4+4*k], fr[5+4*k]});
      for (int b = 0; b < 4; b++) s = s + fr[2+4*k+b];
    end
    csum = fr[2+4*n];
    ok   = (csum == s);
    wr_addr_q.delete();
    wr_data_q.delete();
    do_start(base);
    send_bytes(fr, mode, edges);
    check_val("done", {31'd0, done}, {31'd0, ok});
    check_val("error", {31'd0, error}, {31'd0, !ok});
    check_val("core_hold", {31'd0, core_hold}, {31'd0, !ok});
    check_val("rx_ready_end", {31'd0, rx_ready}, 32'd0);
    if (mode == 0) check_val("latency", edges, 3 + 5 * n);
    check_val("nwrites", wr_addr_q.size(), n);
    for (int k = 0; k < n && k < wr_addr_q.size(); k++) begin
      check_val("wr_addr", {16'd0, wr_addr_q[k]}, {16'd0, 16'(base + 16'(k))});
      check_val("wr_data", wr_data_q[k], words[k]);
    end
    $display("frame base=%h n=%0d csum=%h model_sum=%h mode=%0d writes=%0d done=%0d error=%0d",
             base, n, csum, s, mode, wr_addr_q.size(), done, error);
  endtask

  function automatic bq_t make_frame(input int n, input bit good);
    bq_t        fr;
    logic [7:0] s;
    logic [7:0] b;
    logic [7:0] x;
    fr.delete();
    s = 8'd0;
    fr.push_back(8'(n >> 8));
    fr.push_back(8'(n));
    for (int k = 0; k < 4 * n; k++) begin
      b = 8'($urandom);
      fr.push_back(b);
      s = s + b;
    end
    x = 8'($urandom_range(1, 255));
    fr.push_back(good ? s : (s ^ x));
    return fr;
  endfunction

  initial begin
    bq_t fr;
    int  edges;
    reset = 1'b1; start = 1'b0; base_addr = 16'd0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (2) @(posedge clk); #1;
    check_val("rst_ready", {31'd0, rx_ready}, 32'd0);
    check_val("rst_we", {31'd0, pm_we}, 32'd0);
    check_val("rst_addr", {16'd0, pm_addr}, 32'd0);
    check_val("rst_wdata", pm_wdata, 32'd0);
    check_val("rst_hold", {31'd0, core_hold}, 32'd1);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic load, then same frame with a bad checksum, then zero length.
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
    run_frame(16'h0010, fr, 0);
    fr[10] = 8'h39;
    run_frame(16'h0010, fr, 0);
    fr = '{8'h00, 8'h00, 8'h00};
    run_frame(16'h1234, fr, 0);

    // Address wrap with valid toggling every other cycle.
    run_frame(16'hFFFF, make_frame(2, 1'b1), 1);

    // A start pulse mid-frame must be ignored.
    wr_addr_q.delete();
    wr_data_q.delete();
    do_start(16'h0200);
    fr = '{8'h00, 8'h01, 8'h11};
    send_bytes(fr, 0, edges);
    start = 1'b1; base_addr = 16'h0300;
    @(posedge clk); #1;
    start = 1'b0;
    fr = '{8'h22, 8'h33, 8'h44, 8'hAA};
    send_bytes(fr, 0, edges);
    check_val("ign_done", {31'd0, done}, 32'd1);
    check_val("ign_nwr", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check_val("ign_addr", {16'd0, wr_addr_q[0]}, 32'h0200);
      check_val("ign_data", wr_data_q[0], 32'h11223344);
    end
    $display("frame ignored-start base=0200 writes=%0d done=%0d", wr_addr_q.size(), done);

    // Timeout in the middle of a word: no write, error after TMO idle cycles.
    wr_addr_q.delete();
    wr_data_q.delete();
    do_start(16'h0100);
    fr = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
    send_bytes(fr, 0, edges);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check_val("tmo_early", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    check_val("tmo_error", {31'd0, error}, 32'd1);
    check_val("tmo_done", {31'd0, done}, 32'd0);
    check_val("tmo_hold", {31'd0, core_hold}, 32'd1);
    check_val("tmo_nwr", wr_addr_q.size(), 0);
    $display("frame timeout base=0100 writes=%0d error=%0d", wr_addr_q.size(), error);
    run_frame(16'h0100, make_frame(1, 1'b1), 0);

    // Reset after two data bytes; outputs must drop to reset values at once.
    do_start(16'h0040);
    fr = '{8'h00, 8'h01, 8'h01, 8'h02};
    send_bytes(fr, 0, edges);
    #2;
    reset = 1'b1;
    #1;
    check_val("mrst_ready", {31'd0, rx_ready}, 32'd0);
    check_val("mrst_we", {31'd0, pm_we}, 32'd0);
    check_val("mrst_addr", {16'd0, pm_addr}, 32'd0);
    check_val("mrst_wdata", pm_wdata, 32'd0);
    check_val("mrst_hold", {31'd0, core_hold}, 32'd1);
    check_val("mrst_done", {31'd0, done}, 32'd0);
    check_val("mrst_error", {31'd0, error}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    $display("frame reset-mid-word base=0040");
    run_frame(16'h0050, make_frame(2, 1'b1), 0);

    // Randomised sessions.
    for (int t = 0; t < 14; t++) begin
      run_frame(16'($urandom), make_frame($urandom_range(0, 4), ($urandom % 4) != 0),
                $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=hang exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
